// File: rtl/hdlverifier_trigger_sequencer.sv
// Multi-stage trigger sequencer feeding the capture core trigger input.
// Define SEQ_TIMEOUT_EN to build the per-stage timeout, seq_reset and stage_reset logic.
module hdlverifier_trigger_sequencer #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned TO_WIDTH   = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clk_enable,
  input  logic                            start,
  input  logic                            ready_to_capture,
  input  logic [NUM_STAGES-1:0]           stage_match,
  input  logic [NUM_STAGES*CNT_WIDTH-1:0] stage_count,
  input  logic [3:0]                      last_stage,
  input  logic [TO_WIDTH-1:0]             timeout,
  output logic                            trigger,
  output logic [3:0]                      current_stage,
  output logic [3:0]                      stage_reset,
  output logic                            seq_reset,
  output logic                            armed
);

  typedef enum logic [1:0] {StIdle, StArmed, StRun, StDone} state_e;

  localparam logic [3:0] LastMax = 4'(NUM_STAGES - 1);

  state_e                          state_q, state_d;
  logic                            start_d1;
  logic [NUM_STAGES*CNT_WIDTH-1:0] cnt_sh_q, cnt_sh_d;
  logic [3:0]                      last_sh_q, last_sh_d;
  logic [CNT_WIDTH:0]              hit_q, hit_d, hit_inc, thr_sel;
  logic [3:0]                      cur_q, cur_d;
  logic                            trig_q, trig_d;
  logic                            armed_q, armed_d;
  logic                            match_sel, stage_done;

`ifdef SEQ_TIMEOUT_EN
  logic [TO_WIDTH-1:0] to_sh_q, to_sh_d, to_q, to_d, to_inc;
  logic [3:0]          srst_q, srst_d;
  logic                seqr_q, seqr_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout;
`endif

  // Select the comparator and threshold of the active stage; a threshold of 0 acts as 1.
  always_comb begin
    match_sel = 1'b0;
    thr_sel   = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (cur_q == 4'(i)) begin
        match_sel = stage_match[i];
        thr_sel   = {1'b0, cnt_sh_q[i*CNT_WIDTH +: CNT_WIDTH]};
      end
    end
    if (thr_sel == '0) thr_sel = {{CNT_WIDTH{1'b0}}, 1'b1};
  end

  assign hit_inc    = hit_q + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign stage_done = match_sel && (hit_inc >= thr_sel);

`ifdef SEQ_TIMEOUT_EN
  assign to_inc = (to_q == '1) ? to_q : to_q + 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_sh_d  = cnt_sh_q;
    last_sh_d = last_sh_q;
    hit_d     = hit_q;
    cur_d     = cur_q;
    trig_d    = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    to_sh_d   = to_sh_q;
    to_d      = to_q;
    srst_d    = srst_q;
    seqr_d    = 1'b0;
`endif
    if (clk_enable) begin
      if (start && !start_d1) begin
        state_d   = StArmed;
        cnt_sh_d  = stage_count;
        last_sh_d = (last_stage > LastMax) ? LastMax : last_stage;
        hit_d     = '0;
        cur_d     = '0;
`ifdef SEQ_TIMEOUT_EN
        to_sh_d   = timeout;
        to_d      = '0;
        srst_d    = '0;
`endif
      end else if (!start) begin
        state_d = StIdle;
        hit_d   = '0;
        cur_d   = '0;
`ifdef SEQ_TIMEOUT_EN
        to_d    = '0;
        srst_d  = '0;
`endif
      end else begin
        unique case (state_q)
          StArmed: if (ready_to_capture) state_d = StRun;
          StRun: begin
            if (stage_done) begin
              hit_d = '0;
`ifdef SEQ_TIMEOUT_EN
              to_d  = '0;
`endif
              if (cur_q == last_sh_q) begin
                trig_d  = 1'b1;
                state_d = StDone;
              end else begin
                cur_d = cur_q + 4'd1;
              end
            end else begin
              hit_d = hit_q + {{CNT_WIDTH{1'b0}}, match_sel};
`ifdef SEQ_TIMEOUT_EN
              // Completion has priority, so a timeout is only considered here.
              if ((cur_q != 4'd0) && (to_sh_q != '0)) begin
                if (to_inc == to_sh_q) begin
                  seqr_d = 1'b1;
                  cur_d  = '0;
                  hit_d  = '0;
                  to_d   = '0;
                  if (srst_q != 4'hf) srst_d = srst_q + 4'd1;
                end else begin
                  to_d = to_inc;
                end
              end
`endif
            end
          end
          default: ;
        endcase
      end
    end
    armed_d = (state_d == StArmed) || (state_d == StRun);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      start_d1  <= 1'b0;
      cnt_sh_q  <= '0;
      last_sh_q <= '0;
      hit_q     <= '0;
      cur_q     <= '0;
      trig_q    <= 1'b0;
      armed_q   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      to_sh_q   <= '0;
      to_q      <= '0;
      srst_q    <= '0;
      seqr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      if (clk_enable) start_d1 <= start;
      cnt_sh_q  <= cnt_sh_d;
      last_sh_q <= last_sh_d;
      hit_q     <= hit_d;
      cur_q     <= cur_d;
      trig_q    <= trig_d;
      armed_q   <= armed_d;
`ifdef SEQ_TIMEOUT_EN
      to_sh_q   <= to_sh_d;
      to_q      <= to_d;
      srst_q    <= srst_d;
      seqr_q    <= seqr_d;
`endif
    end
  end

  assign trigger       = trig_q;
  assign current_stage = cur_q;
  assign armed         = armed_q;
`ifdef SEQ_TIMEOUT_EN
  assign stage_reset   = srst_q;
  assign seq_reset     = seqr_q;
`else
  assign stage_reset   = 4'd0;
  assign seq_reset     = 1'b0;
`endif

endmodule

// File: tb/tb_hdlverifier_trigger_sequencer.sv
// Self-checking bench for hdlverifier_trigger_sequencer; trigger and seq_reset pulses are
// matched against a queue of expected cycle numbers.
module tb_hdlverifier_trigger_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        start;
  logic        ready_to_capture;
  logic [3:0]  stage_match;
  logic [31:0] stage_count;
  logic [3:0]  last_stage;
  logic [15:0] timeout;
  logic        trigger;
  logic [3:0]  current_stage;
  logic [3:0]  stage_reset;
  logic        seq_reset;
  logic        armed;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int trig_q[$];
  int seqr_q[$];
  int mon_exp;

  hdlverifier_trigger_sequencer #(
    .NUM_STAGES(4),
    .CNT_WIDTH (8),
    .TO_WIDTH  (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .clk_enable      (clk_enable),
    .start           (start),
    .ready_to_capture(ready_to_capture),
    .stage_match     (stage_match),
    .stage_count     (stage_count),
    .last_stage      (last_stage),
    .timeout         (timeout),
    .trigger         (trigger),
    .current_stage   (current_stage),
    .stage_reset     (stage_reset),
    .seq_reset       (seq_reset),
    .armed           (armed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every pulse must match the next expected cycle number.
  always @(negedge clk) begin
    if (!reset) begin
      if (trigger) begin
        checks++;
        if (trig_q.size() == 0) begin
          errors++;
          $display("FAIL trigger_pulse unexpected at cycle %0d", cyc);
        end else begin
          mon_exp = trig_q.pop_front();
          if (mon_exp != cyc) begin
            errors++;
            $display("FAIL trigger_pulse cycle got %0d want %0d", cyc, mon_exp);
          end
        end
      end
      if (seq_reset) begin
        checks++;
        if (seqr_q.size() == 0) begin
          errors++;
          $display("FAIL seq_reset_pulse unexpected at cycle %0d", cyc);
        end else begin
          mon_exp = seqr_q.pop_front();
          if (mon_exp != cyc) begin
            errors++;
            $display("FAIL seq_reset_pulse cycle got %0d want %0d", cyc, mon_exp);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns the cycle number of the edge that enters ARMED.
  task automatic arm(output int a);
    start = 1'b0;
    step();
    start = 1'b1;
    a = cyc + 1;
    step();
  endtask

  task automatic disarm();
    start = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clk_enable = 1'b1;
    start = 1'b0;
    ready_to_capture = 1'b1;
    stage_match = 4'h0;
    stage_count = 32'h0;
    last_stage = 4'd0;
    timeout = 16'd0;
    #1;
    checks++;
    if ({trigger, current_stage, stage_reset, seq_reset, armed} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0",
               {trigger, current_stage, stage_reset, seq_reset, armed});
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    checks++;
    if ({trigger, current_stage, armed} !== 6'd0) begin
      errors++;
      $display("FAIL idle_after_reset got %b want 0", {trigger, current_stage, armed});
    end
  endtask

  task automatic test_basic_chain();
    int a;
    int exp_cur[9] = '{0, 0, 1, 1, 2, 3, 3, 3, 3};
    stage_count = {8'd3, 8'd1, 8'd2, 8'd1};
    last_stage = 4'd3;
    timeout = 16'd0;
    ready_to_capture = 1'b1;
    stage_match = 4'hf;
    arm(a);
    trig_q.push_back(a + 8);
    for (int j = 0; j < 9; j++) begin
      if (j > 0) step();
      checks++;
      if (current_stage !== 4'(exp_cur[j])) begin
        errors++;
        $display("FAIL chain_stage[%0d] got %0d want %0d", j, current_stage, exp_cur[j]);
      end
      checks++;
      if (armed !== (j < 8)) begin
        errors++;
        $display("FAIL chain_armed[%0d] got %0d want %0d", j, armed, (j < 8));
      end
      checks++;
      if (trigger !== (j == 8)) begin
        errors++;
        $display("FAIL chain_trigger[%0d] got %0d want %0d", j, trigger, (j == 8));
      end
    end
    step();
    checks++;
    if ({trigger, current_stage, armed} !== {1'b0, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL chain_done got %b want %b", {trigger, current_stage, armed},
               {1'b0, 4'd3, 1'b0});
    end
    disarm();
  endtask

  task automatic test_handshake_enable();
    int a;
    int hits = 0;
    bit running = 0;
    int exp_cur;
    stage_count = {8'd1, 8'd1, 8'd255, 8'd3};
    last_stage = 4'd3;
    timeout = 16'd0;
    stage_match = 4'hf;
    ready_to_capture = 1'b0;
    arm(a);
    repeat (10) step();
    checks++;
    if ({armed, current_stage} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL handshake_hold got %b want %b", {armed, current_stage}, {1'b1, 4'd0});
    end
    ready_to_capture = 1'b1;
    for (int i = 0; i < 10; i++) begin
      clk_enable = (i % 2 == 0);
      step();
      if (clk_enable) begin
        if (!running) running = 1;
        else hits++;
      end
      exp_cur = (hits >= 3) ? 1 : 0;
      checks++;
      if (current_stage !== 4'(exp_cur)) begin
        errors++;
        $display("FAIL enable_stage[%0d] got %0d want %0d", i, current_stage, exp_cur);
      end
    end
    clk_enable = 1'b1;
    disarm();
  endtask

  task automatic test_disarm_and_reset();
    int a;
    stage_count = {8'd3, 8'd1, 8'd2, 8'd1};
    last_stage = 4'd3;
    timeout = 16'd0;
    stage_match = 4'hf;
    arm(a);
    repeat (4) step();
    checks++;
    if (current_stage !== 4'd2) begin
      errors++;
      $display("FAIL disarm_pre_stage got %0d want 2", current_stage);
    end
    start = 1'b0;
    step();
    checks++;
    if ({armed, current_stage} !== 5'd0) begin
      errors++;
      $display("FAIL disarm_idle got %b want 0", {armed, current_stage});
    end
    repeat (8) step();
    // Reset in the middle of a trigger pulse; no scoreboard entry since the pulse is cut.
    arm(a);
    repeat (8) step();
    checks++;
    if (trigger !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_trigger got %0d want 1", trigger);
    end
    #2;
    reset = 1'b1;
    start = 1'b0;
    #1;
    checks++;
    if ({trigger, current_stage, stage_reset, seq_reset, armed} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset got %b want 0",
               {trigger, current_stage, stage_reset, seq_reset, armed});
    end
    #3;
    reset = 1'b0;
    step();
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int a;
    int exp_sr;
    stage_count = {8'd1, 8'd1, 8'd1, 8'd1};
    last_stage = 4'd3;
    timeout = 16'd5;
    stage_match = 4'b0001;
    arm(a);
    for (int k = 0; k < 17; k++) seqr_q.push_back(a + 7 + 6 * k);
    step();
    for (int k = 0; k < 17; k++) begin
      repeat (5) step();
      checks++;
      if ({seq_reset, current_stage} !== {1'b0, 4'd1}) begin
        errors++;
        $display("FAIL timeout_wait[%0d] got %b want %b", k, {seq_reset, current_stage},
                 {1'b0, 4'd1});
      end
      step();
      exp_sr = (k + 1 > 15) ? 15 : k + 1;
      checks++;
      if ({seq_reset, current_stage, stage_reset} !== {1'b1, 4'd0, 4'(exp_sr)}) begin
        errors++;
        $display("FAIL timeout_fire[%0d] got %b want %b", k,
                 {seq_reset, current_stage, stage_reset}, {1'b1, 4'd0, 4'(exp_sr)});
      end
    end
    disarm();
  endtask

  task automatic test_tie_break();
    int a;
    stage_count = {8'd1, 8'd255, 8'd3, 8'd1};
    last_stage = 4'd3;
    timeout = 16'd3;
    stage_match = 4'b0011;
    arm(a);
    repeat (5) step();
    checks++;
    if ({current_stage, seq_reset, stage_reset} !== {4'd2, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL tie_break got %b want %b", {current_stage, seq_reset, stage_reset},
               {4'd2, 1'b0, 4'd0});
    end
    disarm();
  endtask
`else
  task automatic test_no_timeout();
    int a;
    stage_count = {8'd1, 8'd1, 8'd1, 8'd1};
    last_stage = 4'd3;
    timeout = 16'd3;
    stage_match = 4'b0001;
    arm(a);
    repeat (2) step();
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (seq_reset !== 1'b0) begin
        errors++;
        $display("FAIL no_timeout_seq_reset[%0d] got %0d want 0", i, seq_reset);
      end
    end
    checks++;
    if ({current_stage, stage_reset} !== {4'd1, 4'd0}) begin
      errors++;
      $display("FAIL no_timeout_stall got %b want %b", {current_stage, stage_reset},
               {4'd1, 4'd0});
    end
    disarm();
  endtask
`endif

  task automatic test_scoreboard_drained();
    checks++;
    if (trig_q.size() != 0 || seqr_q.size() != 0) begin
      errors++;
      $display("FAIL pulses_missing got trig=%0d seq=%0d pending want 0", trig_q.size(),
               seqr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_chain();
    test_handshake_enable();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
    test_tie_break();
`else
    test_no_timeout();
`endif
    test_disarm_and_reset();
    test_scoreboard_drained();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
